// File: rtl/shift_engine_pkg.sv
// Shared types and constants for the shift_engine serialiser/deserialiser.
// The FSM hands the shift register one of the se_mode_t commands each cycle.
package shift_engine_pkg;

  typedef enum logic [1:0] {
    SE_IDLE  = 2'd0,
    SE_SHIFT = 2'd1,
    SE_DONE  = 2'd2
  } se_state_t;

  typedef logic [1:0] se_mode_t;

  localparam se_mode_t SE_HOLD  = 2'b00;
  localparam se_mode_t SE_RIGHT = 2'b01;
  localparam se_mode_t SE_LEFT  = 2'b10;
  localparam se_mode_t SE_LOAD  = 2'b11;

endpackage

// File: rtl/shift_engine_sr_counter.sv
// Synchronous-reset up-counter with clear and increment; clear wins over increment.
module sr_counter #(
  parameter int COUNTER_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     inc_i,
  output logic [COUNTER_WIDTH-1:0] count_o
);

  logic [COUNTER_WIDTH-1:0] count_q;
  logic [COUNTER_WIDTH-1:0] count_d;

  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + COUNTER_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/shift_engine.sv
// Serialiser/deserialiser: loads a word on a valid/ready handshake, shifts it out
// MSB- or LSB-first on bit ticks while capturing serial_in, and pulses done.
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter  int                    DATA_WIDTH  = 8,
  parameter  logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int                    CNT_WIDTH   = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  msb_first,
  input  logic                  shift_en,
  input  logic                  abort,
  input  logic                  serial_in,
  output logic                  serial_out,
  output logic [DATA_WIDTH-1:0] pout,
  output logic [CNT_WIDTH-1:0]  bit_cnt,
  output logic                  busy,
  output logic                  done
);

  se_state_t             state_q, state_d;
  se_mode_t              mode;
  logic                  cnt_clr, cnt_inc;
  logic [DATA_WIDTH-1:0] pout_q, pout_d;
  logic                  order_q, order_d;
  logic                  last_shift;

  // The tick that takes bit_cnt from W-1 to W is the final shift of the word.
  assign last_shift = (bit_cnt == CNT_WIDTH'(DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SE_IDLE:  if (ld_valid) state_d = SE_SHIFT;
      SE_SHIFT: begin
        if (abort) begin
          state_d = SE_IDLE;
        end else if (shift_en && last_shift) begin
          state_d = SE_DONE;
        end
      end
      SE_DONE:  state_d = SE_IDLE;
      default:  state_d = SE_IDLE;
    endcase
  end

  always_comb begin
    mode    = SE_HOLD;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      SE_IDLE: begin
        if (ld_valid) begin
          mode    = SE_LOAD;
          cnt_clr = 1'b1;
        end
      end
      SE_SHIFT: begin
        if (shift_en && !abort) begin
          mode    = order_q ? SE_LEFT : SE_RIGHT;
          cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pout_d  = pout_q;
    order_d = order_q;
    unique case (mode)
      SE_LOAD: begin
        pout_d  = ld_data;
        order_d = msb_first;
      end
      SE_LEFT:  pout_d = {pout_q[DATA_WIDTH-2:0], serial_in};
      SE_RIGHT: pout_d = {serial_in, pout_q[DATA_WIDTH-1:1]};
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pout_q  <= RESET_VALUE;
      order_q <= 1'b1;
    end else begin
      pout_q  <= pout_d;
      order_q <= order_d;
    end
  end

  sr_counter #(
    .COUNTER_WIDTH(CNT_WIDTH)
  ) u_bit_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .count_o(bit_cnt)
  );

  assign pout       = pout_q;
  assign serial_out = order_q ? pout_q[DATA_WIDTH-1] : pout_q[0];
  assign ld_ready   = (state_q == SE_IDLE);
  assign busy       = (state_q != SE_IDLE);
  assign done       = (state_q == SE_DONE);

endmodule

// File: tb/tb_shift_engine.sv
// Directed-vector bench for shift_engine (DATA_WIDTH=8) with hand-computed expectations.
module tb_shift_engine;

  logic       clk = 1'b0;
  logic       reset, ld_valid, msb_first, shift_en, abort, serial_in;
  logic [7:0] ld_data;
  logic       ld_ready, serial_out, busy, done;
  logic [7:0] pout;
  logic [3:0] bit_cnt;

  int n_vec = 0;
  int n_err = 0;

  shift_engine dut (
    .clk       (clk),
    .reset     (reset),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .msb_first (msb_first),
    .shift_en  (shift_en),
    .abort     (abort),
    .serial_in (serial_in),
    .serial_out(serial_out),
    .pout      (pout),
    .bit_cnt   (bit_cnt),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] data, input logic msb);
    ld_data   = data;
    msb_first = msb;
    ld_valid  = 1'b1;
    tick();
    ld_valid  = 1'b0;
  endtask

  // Eight back-to-back MSB-first shifts: so_seq is the expected outgoing word, rx the incoming one.
  task automatic shift_msb(input string tag, input logic [7:0] so_seq, input logic [7:0] rx);
    logic [7:0] so_w, rx_w;
    so_w = so_seq;
    rx_w = rx;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_so%0d", tag, i), serial_out, so_w[7-i]);
      check($sformatf("%s_nodone%0d", tag, i), done, 1'b0);
      serial_in = rx_w[7-i];
      shift_en  = 1'b1;
      tick();
    end
    shift_en = 1'b0;
  endtask

  initial begin
    logic [7:0] so3;
    reset = 1'b1; ld_valid = 1'b1; ld_data = 8'hFF; msb_first = 1'b1;
    shift_en = 1'b0; abort = 1'b0; serial_in = 1'b0;

    // 1: reset dominates a pending load
    tick(); tick();
    check("rst_pout", pout, 8'h00);
    check("rst_cnt", bit_cnt, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0; ld_valid = 1'b0;
    check("rst_ready", ld_ready, 1'b1);

    // 2: MSB-first, shift every cycle
    load(8'hA5, 1'b1);
    check("t2_busy", busy, 1'b1);
    check("t2_ready", ld_ready, 1'b0);
    check("t2_cnt0", bit_cnt, 4'd0);
    shift_msb("t2", 8'hA5, 8'h3C);
    check("t2_done", done, 1'b1);
    check("t2_pout", pout, 8'h3C);
    check("t2_cnt", bit_cnt, 4'd8);
    tick();
    check("t2_done_off", done, 1'b0);
    check("t2_idle", busy, 1'b0);

    // 3: LSB-first, one tick every third cycle
    load(8'h01, 1'b0);
    serial_in = 1'b1;
    so3 = 8'b1000_0000;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_so%0d", i), serial_out, so3[7-i]);
      for (int j = 0; j < 2; j++) begin
        tick();
        check($sformatf("t3_nodone%0d_%0d", i, j), done, 1'b0);
        check($sformatf("t3_hold%0d_%0d", i, j), bit_cnt, 4'(i));
      end
      shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
    end
    check("t3_done", done, 1'b1);
    check("t3_pout", pout, 8'hFF);
    tick();
    check("t3_done_off", done, 1'b0);

    // 4: abort together with the fourth tick
    load(8'hC3, 1'b1);
    serial_in = 1'b0;
    shift_en  = 1'b1;
    tick(); tick(); tick();
    check("t4_pout3", pout, 8'h18);
    abort = 1'b1;
    tick();
    abort = 1'b0; shift_en = 1'b0;
    check("t4_idle", busy, 1'b0);
    check("t4_done", done, 1'b0);
    check("t4_cnt", bit_cnt, 4'd3);
    check("t4_pout", pout, 8'h18);
    tick();
    check("t4_still_no_done", done, 1'b0);

    // 5: ld_valid held through SHIFT and DONE
    ld_data = 8'h96; msb_first = 1'b1; ld_valid = 1'b1;
    tick();
    ld_data = 8'h5A;
    shift_msb("t5a", 8'h96, 8'hFF);
    check("t5_done", done, 1'b1);
    check("t5_pout", pout, 8'hFF);
    check("t5_ready_done", ld_ready, 1'b0);
    tick();
    check("t5_ready_idle", ld_ready, 1'b1);
    check("t5_pout_idle", pout, 8'hFF);
    tick();
    ld_valid = 1'b0;
    check("t5_reload_busy", busy, 1'b1);
    check("t5_reload_pout", pout, 8'h5A);
    check("t5_reload_cnt", bit_cnt, 4'd0);
    shift_msb("t5b", 8'h5A, 8'h00);
    check("t5b_done", done, 1'b1);
    check("t5b_pout", pout, 8'h00);
    tick();

    // 6: reset after five shifts, then a clean transfer
    load(8'hF0, 1'b0);
    serial_in = 1'b1; shift_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t6_cnt5", bit_cnt, 4'd5);
    reset = 1'b1; shift_en = 1'b0;
    tick();
    reset = 1'b0;
    check("t6_rst_pout", pout, 8'h00);
    check("t6_rst_cnt", bit_cnt, 4'd0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_done", done, 1'b0);
    check("t6_rst_ready", ld_ready, 1'b1);
    load(8'h81, 1'b1);
    shift_msb("t6", 8'h81, 8'h6B);
    check("t6_done", done, 1'b1);
    check("t6_pout", pout, 8'h6B);
    check("t6_cnt", bit_cnt, 4'd8);
    tick();
    check("t6_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
